// File: rtl/ascon_pt_encrypt_if.sv
// ascon_pt_encrypt_if
// Groups the control, plaintext-input, ciphertext-output and hand-off signals
// of the ASCON-128 plaintext encryption stage.
//   start/state_in          : load request and the 320-bit state from the AD stage
//   pt_valid/pt_ready/...   : plaintext block stream (pt_data, pt_last, pt_bytes)
//   ct_valid/ct_data/...    : ciphertext block stream (ct_bytes, ct_last)
//   busy/done/state_out     : status and the state handed to finalization
// The master modport is the upstream/environment side, the slave modport is
// the encryption stage itself.
interface ascon_pt_encrypt_if;
    logic         start;
    logic [319:0] state_in;
    logic         pt_valid;
    logic         pt_ready;
    logic [63:0]  pt_data;
    logic         pt_last;
    logic [3:0]   pt_bytes;
    logic         ct_valid;
    logic [63:0]  ct_data;
    logic [3:0]   ct_bytes;
    logic         ct_last;
    logic         busy;
    logic         done;
    logic [319:0] state_out;

    modport master (
        output start, state_in, pt_valid, pt_data, pt_last, pt_bytes,
        input  pt_ready, ct_valid, ct_data, ct_bytes, ct_last, busy, done, state_out
    );

    modport slave (
        input  start, state_in, pt_valid, pt_data, pt_last, pt_bytes,
        output pt_ready, ct_valid, ct_data, ct_bytes, ct_last, busy, done, state_out
    );
endinterface

// File: rtl/ascon_pt_encrypt.sv
// ascon_pt_encrypt
// ASCON-128 plaintext processing stage. Loads the post-AD state, absorbs
// 64-bit plaintext blocks into x0, emits the matching ciphertext blocks and
// runs ROUNDS permutation rounds (one per cycle) after every full block. The
// final (possibly empty) block is padded, no permutation follows, and the
// state is handed to finalization on state_out together with a done pulse.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : ascon_pt_encrypt_if.slave (start/state_in, pt_*, ct_*, busy, done,
//          state_out)
module ascon_pt_encrypt #(
    parameter int ROUNDS    = 6,
    parameter int RATE_BITS = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    ascon_pt_encrypt_if.slave       bus
);

    localparam int W = RATE_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ABSORB = 2'd1,
        PERM   = 2'd2,
        FINAL  = 2'd3
    } fsm_t;

    fsm_t           state_q, state_d;
    logic [2:0]     rnd_q, rnd_d;
    logic [319:0]   s_q, s_d;

    logic           ct_valid_q;
    logic [W-1:0]   ct_data_q;
    logic [3:0]     ct_bytes_q;
    logic           ct_last_q;
    logic           done_q;
    logic [319:0]   state_out_q;

    logic           ct_load;
    logic           ct_last_d;
    logic [W-1:0]   ct_data_d;
    logic [3:0]     ct_bytes_d;
    logic           fin;

    logic [2:0]     last_n;
    logic [W-1:0]   keep;
    logic [W-1:0]   pad;
    logic [W-1:0]   msg;
    logic [W-1:0]   x0_mix;

    // Values 8..15 on pt_bytes are a protocol violation; only [2:0] counts.
    logic           unused_bytes_msb;
    assign unused_bytes_msb = bus.pt_bytes[3];

    function automatic logic [W-1:0] ror64(input logic [W-1:0] v, input int unsigned n);
        return (v >> n) | (v << (W - n));
    endfunction

    // Constants are the tail of the 12-round table: entry i is {~i, i}.
    function automatic logic [7:0] round_const(input logic [2:0] r);
        logic [3:0] i;
        i = 4'(12 - ROUNDS) + {1'b0, r};
        return {4'hF - i, i};
    endfunction

    // Upper n bytes of a block kept, the rest cleared.
    function automatic logic [W-1:0] keep_mask(input logic [2:0] n);
        return ~({W{1'b1}} >> {n, 3'b000});
    endfunction

    // Padding byte 0x80 sitting right after the last message byte.
    function automatic logic [W-1:0] pad_bits(input logic [2:0] n);
        return {1'b1, {(W-1){1'b0}}} >> {n, 3'b000};
    endfunction

    // One ASCON round: constant addition, bitsliced S-box, linear layer.
    function automatic logic [319:0] perm_round(input logic [319:0] s, input logic [7:0] c);
        logic [W-1:0] x0, x1, x2, x3, x4;
        logic [W-1:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];

        x2 = x2 ^ {{(W-8){1'b0}}, c};

        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Final-block masking/padding, computed for whatever is on the bus.
    always_comb begin
        last_n = bus.pt_bytes[2:0];
        keep   = keep_mask(last_n);
        pad    = pad_bits(last_n);
        msg    = bus.pt_data & keep;
        x0_mix = s_q[319:256] ^ msg;
    end

    always_comb begin
        state_d    = state_q;
        rnd_d      = rnd_q;
        s_d        = s_q;
        ct_load    = 1'b0;
        ct_last_d  = 1'b0;
        ct_data_d  = '0;
        ct_bytes_d = '0;
        fin        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    s_d     = bus.state_in;
                    state_d = ABSORB;
                end
            end
            ABSORB: begin
                if (bus.pt_valid) begin
                    ct_load = 1'b1;
                    if (!bus.pt_last) begin
                        ct_data_d  = s_q[319:256] ^ bus.pt_data;
                        ct_bytes_d = 4'd8;
                        s_d        = {s_q[319:256] ^ bus.pt_data, s_q[255:0]};
                        rnd_d      = 3'd0;
                        state_d    = PERM;
                    end else begin
                        ct_data_d  = x0_mix & keep;
                        ct_bytes_d = {1'b0, last_n};
                        ct_last_d  = 1'b1;
                        s_d        = {x0_mix ^ pad, s_q[255:0]};
                        fin        = 1'b1;
                        state_d    = FINAL;
                    end
                end
            end
            PERM: begin
                s_d = perm_round(s_q, round_const(rnd_q));
                if (rnd_q == 3'(ROUNDS - 1)) begin
                    rnd_d   = 3'd0;
                    state_d = ABSORB;
                end else begin
                    rnd_d = rnd_q + 3'd1;
                end
            end
            FINAL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The final state and done are registered on the last-block handshake so
    // that done lines up with the last ciphertext pulse; FINAL is the one
    // cycle in which both are presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rnd_q       <= 3'd0;
            s_q         <= '0;
            ct_valid_q  <= 1'b0;
            ct_data_q   <= '0;
            ct_bytes_q  <= '0;
            ct_last_q   <= 1'b0;
            done_q      <= 1'b0;
            state_out_q <= '0;
        end else begin
            state_q    <= state_d;
            rnd_q      <= rnd_d;
            s_q        <= s_d;
            ct_valid_q <= ct_load;
            ct_last_q  <= ct_last_d;
            done_q     <= fin;
            if (ct_load) begin
                ct_data_q  <= ct_data_d;
                ct_bytes_q <= ct_bytes_d;
            end
            if (fin) begin
                state_out_q <= s_d;
            end
        end
    end

    assign bus.pt_ready  = (state_q == ABSORB);
    assign bus.busy      = (state_q != IDLE);
    assign bus.ct_valid  = ct_valid_q;
    assign bus.ct_data   = ct_data_q;
    assign bus.ct_bytes  = ct_bytes_q;
    assign bus.ct_last   = ct_last_q;
    assign bus.done      = done_q;
    assign bus.state_out = state_out_q;

endmodule

// File: tb/tb_ascon_pt_encrypt.sv
// tb_ascon_pt_encrypt
// Directed bench for ascon_pt_encrypt: hand-computed vectors for the short
// cases, and a table-driven ASCON reference (S-box lookup, literal round
// constant table) for the cases that run the permutation.
module tb_ascon_pt_encrypt;

    localparam int ROUNDS = 6;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam logic [7:0] RC [12] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    int   ct_cnt;
    logic [319:0] ms;

    ascon_pt_encrypt_if bus();

    ascon_pt_encrypt #(.ROUNDS(ROUNDS), .RATE_BITS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.ct_valid === 1'b1) ct_cnt <= ct_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---- reference model ----
    function automatic logic [63:0] rr(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v} >> n;
        return d[63:0];
    endfunction

    function automatic logic [319:0] m_perm(input logic [319:0] s, input int nr);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  idx;
        logic [4:0]  o;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
        for (int r = 12 - nr; r < 12; r++) begin
            x[2] = x[2] ^ {56'd0, RC[r]};
            for (int j = 0; j < 64; j++) begin
                idx = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
                o   = SBOX[idx];
                y[0][j] = o[4];
                y[1][j] = o[3];
                y[2][j] = o[2];
                y[3][j] = o[1];
                y[4][j] = o[0];
            end
            x[0] = y[0] ^ rr(y[0], 19) ^ rr(y[0], 28);
            x[1] = y[1] ^ rr(y[1], 61) ^ rr(y[1], 39);
            x[2] = y[2] ^ rr(y[2], 1)  ^ rr(y[2], 6);
            x[3] = y[3] ^ rr(y[3], 10) ^ rr(y[3], 17);
            x[4] = y[4] ^ rr(y[4], 7)  ^ rr(y[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    task automatic m_full(input logic [63:0] pt, output logic [63:0] ct);
        ct = ms[319:256] ^ pt;
        ms[319:256] = ct;
        ms = m_perm(ms, ROUNDS);
    endtask

    task automatic m_last(input logic [63:0] pt, input int n, output logic [63:0] ct);
        logic [63:0] x0;
        logic [7:0]  b;
        x0 = ms[319:256];
        ct = '0;
        for (int k = 0; k < 8; k++) begin
            b = pt[63 - 8*k -: 8];
            if (k < n) begin
                x0[63 - 8*k -: 8] = x0[63 - 8*k -: 8] ^ b;
                ct[63 - 8*k -: 8] = x0[63 - 8*k -: 8];
            end else if (k == n) begin
                x0[63 - 8*k -: 8] = x0[63 - 8*k -: 8] ^ 8'h80;
            end
        end
        ms[319:256] = x0;
    endtask

    // ---- drivers (called at a falling edge) ----
    task automatic do_start(input logic [319:0] s);
        bus.state_in = s;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic send(input logic [63:0] d, input logic last, input logic [3:0] nb,
                        input logic [63:0] exp_ct, input logic [319:0] exp_st, input string tag);
        int n;
        int low;
        bus.pt_data  = d;
        bus.pt_last  = last;
        bus.pt_bytes = nb;
        bus.pt_valid = 1'b1;
        n = 0;
        while (bus.pt_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.pt_ready !== 1'b1) begin
            chk({tag, "_ready_wait"}, 320'(bus.pt_ready), 320'd1);
            bus.pt_valid = 1'b0;
            return;
        end
        @(negedge clk);
        chk({tag, "_ct_valid"}, 320'(bus.ct_valid), 320'd1);
        chk({tag, "_ct_data"},  320'(bus.ct_data),  320'(exp_ct));
        chk({tag, "_ct_bytes"}, 320'(bus.ct_bytes), last ? 320'(nb[2:0]) : 320'd8);
        chk({tag, "_ct_last"},  320'(bus.ct_last),  320'(last));
        if (last) begin
            chk({tag, "_done"},      320'(bus.done), 320'd1);
            chk({tag, "_state_out"}, bus.state_out,  exp_st);
            bus.pt_valid = 1'b0;
            @(negedge clk);
            chk({tag, "_idle_busy"}, 320'(bus.busy),     320'd0);
            chk({tag, "_done_pulse"}, 320'(bus.done),    320'd0);
            chk({tag, "_ct_pulse"},  320'(bus.ct_valid), 320'd0);
        end else begin
            // pt_valid stays high through the permutation on purpose.
            low = 0;
            while (bus.pt_ready !== 1'b1 && low < 50) begin
                low++;
                @(negedge clk);
            end
            chk({tag, "_ready_low"}, 320'(low), 320'(ROUNDS));
            bus.pt_valid = 1'b0;
        end
    endtask

    initial begin
        logic [319:0] sin;
        logic [63:0]  ect;
        logic [63:0]  pts [4];
        int           c0;

        n_chk = 0;
        n_err = 0;
        ct_cnt = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.state_in = '0;
        bus.pt_valid = 1'b0;
        bus.pt_data = '0;
        bus.pt_last = 1'b0;
        bus.pt_bytes = '0;
        repeat (3) @(negedge clk);

        chk("rst_busy",     320'(bus.busy),     320'd0);
        chk("rst_pt_ready", 320'(bus.pt_ready), 320'd0);
        chk("rst_ct_valid", 320'(bus.ct_valid), 320'd0);
        chk("rst_done",     320'(bus.done),     320'd0);
        chk("rst_ct_data",  320'(bus.ct_data),  320'd0);
        chk("rst_ct_bytes", 320'(bus.ct_bytes), 320'd0);
        chk("rst_state",    bus.state_out,      320'd0);
        rst = 1'b0;
        @(negedge clk);

        // Empty message.
        do_start(320'd0);
        chk("t1_pt_ready", 320'(bus.pt_ready), 320'd1);
        send(64'h0, 1'b1, 4'd0, 64'h0, {64'h8000000000000000, 256'h0}, "t1");

        // Full block then empty last block.
        sin = {64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0, 64'h0, 64'h0};
        ms  = sin;
        c0  = ct_cnt;
        do_start(sin);
        send(64'h0123456789ABCDEF, 1'b0, 4'd0, 64'hFEDCBA9876543210, '0, "t3_blk");
        m_full(64'h0123456789ABCDEF, ect);
        m_last(64'h0, 0, ect);
        send(64'h0, 1'b1, 4'd0, ect, ms, "t3_last");
        chk("t3_ct_count", 320'(ct_cnt - c0), 320'd2);

        // Multi-block with a stray start while busy.
        sin = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
               64'h8796a5b4c3d2e1f0, 64'h0000000000000001};
        pts[0] = 64'h5468652071756963;
        pts[1] = 64'h6b2062726f776e20;
        pts[2] = 64'h666f78206a756d70;
        pts[3] = 64'h73206f7665722074;
        ms = sin;
        c0 = ct_cnt;
        do_start(sin);
        bus.state_in = ~sin;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        chk("t4_busy_after_start", 320'(bus.busy), 320'd1);
        for (int b = 0; b < 4; b++) begin
            m_full(pts[b], ect);
            send(pts[b], 1'b0, 4'd0, ect, '0, $sformatf("t4_blk%0d", b));
        end
        m_last(64'h6865206c617a7979, 5, ect);
        send(64'h6865206c617a7979, 1'b1, 4'd5, ect, ms, "t4_last");
        chk("t4_ct_count", 320'(ct_cnt - c0), 320'd5);

        // Reset in the middle of the permutation (round 3).
        do_start(sin);
        bus.pt_data  = pts[0];
        bus.pt_last  = 1'b0;
        bus.pt_valid = 1'b1;
        @(negedge clk);
        bus.pt_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy",     320'(bus.busy),     320'd0);
        chk("t5_pt_ready", 320'(bus.pt_ready), 320'd0);
        chk("t5_state",    bus.state_out,      320'd0);
        chk("t5_ct_data",  320'(bus.ct_data),  320'd0);
        @(negedge clk);
        chk("t5_idle_ready", 320'(bus.pt_ready), 320'd0);

        // Partial last block after the reset.
        do_start(320'd0);
        send(64'hAABBCC1122334455, 1'b1, 4'd3, 64'hAABBCC0000000000,
             {64'hAABBCC8000000000, 256'h0}, "t2");

        // Seven-byte last block straight after load.
        ms = sin;
        m_last(64'h1122334455667788, 7, ect);
        do_start(sin);
        send(64'h1122334455667788, 1'b1, 4'd7, ect, ms, "t6");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ascon_pt_encrypt.md
Name: ascon_pt_encrypt

Overview:
- Downstream neighbour of the associated-data absorption stage in the ASCON-128 core.
- Takes the 320-bit state after AD absorption, with the domain separator already XORed into x4.
- Absorbs plaintext in 64-bit rate blocks, emits ciphertext blocks and runs p6 between full blocks using an internal iterative round unit (one round per cycle).
- On the final (padded) block it hands the 320-bit state to the finalization stage.

Parameters:
- ROUNDS, 6, permutation rounds between plaintext blocks; constants are the last ROUNDS entries of the 12-round table.
- RATE_BITS, 64, rate width; fixed for ASCON-128 and present for documentation only.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; loads state_in, accepted only in IDLE
- state_in  in  320  state from AD stage; x0=[319:256] … x4=[63:0]
- pt_valid  in  1  plaintext block valid
- pt_ready  out  1  block accepted when pt_valid && pt_ready
- pt_data  in  64  plaintext, first byte in [63:56]
- pt_last  in  1  marks final block
- pt_bytes  in  4  valid bytes of final block, 0..7; ignored on non-last blocks, which are always 8 bytes
- ct_valid  out  1  one-cycle pulse, ciphertext valid
- ct_data  out  64  ciphertext, unused low bytes zero
- ct_bytes  out  4  byte count of ct_data (8 or 0..7)
- ct_last  out  1  qualifies the final ciphertext block
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse, state_out valid
- state_out  out  320  state for finalization, held until next start

Behaviour:
- Reset (rst=1 at clk edge), from any state including mid-permutation:
  - FSM goes to IDLE and the round counter clears to 0.
  - pt_ready, ct_valid, ct_last, done and busy go to 0.
  - ct_data, ct_bytes and state_out go to 0; the internal state register goes to 0.
- FSM states: IDLE, ABSORB, PERM, FINAL.
- IDLE:
  - start=1 loads S<=state_in and moves to ABSORB on the next cycle.
  - start in any other state is ignored.
- ABSORB:
  - pt_ready=1, and only in this state.
  - On handshake with pt_last=0:
    - x0<=x0^pt_data.
    - ct_data<=x0^pt_data, ct_bytes<=8, ct_valid pulses the next cycle.
    - Go to PERM with round counter 0.
  - On handshake with pt_last=1, with n=pt_bytes[2:0] (values 8..15 are a protocol violation; only [2:0] is used):
    - m = pt_data with bytes n..7 masked to zero.
    - x0<=x0^m^(0x80 placed at byte n, i.e. bit 63-8n).
    - ct_data<=upper n bytes of x0^m, rest zero; ct_bytes<=n; ct_last=1 with ct_valid.
    - Go to FINAL. No permutation is run.
- PERM:
  - One round per cycle with round constant c_r = 0x96,0x87,0x78,0x69,0x5a,0x4b for r=0..5.
  - Each round applies, in order:
    - constant addition: x2^=c_r
    - 5-bit S-box layer (bitsliced)
    - linear layer: x0 rot 19/28, x1 61/39, x2 1/6, x3 10/17, x4 7/41 (right rotations, XORed)
  - After round ROUNDS-1, return to ABSORB.
  - pt_ready is low for exactly ROUNDS cycles.
- FINAL:
  - state_out<=S and done=1 for one cycle, then IDLE.
- Latency:
  - Handshake to ct_valid: 1 cycle.
  - Full block handshake to next pt_ready: ROUNDS+1 cycles.
  - Last block handshake to done: 1 cycle, concurrent with ct_valid.
- Boundary rules:
  - Zero-length plaintext is a single last block with pt_bytes=0.
  - A plaintext that is a multiple of 8 bytes ends with an empty last block.
  - pt_valid while pt_ready=0 is held off; inputs are sampled only on handshake.
- Width rules: all XORs are 64-bit, rotations are modulo 64, and the round counter is 3 bits.

Test Plan:
- Empty message: state_in=0, start, then last block pt_bytes=0 -> ct_valid with ct_bytes=0, ct_data=0, ct_last=1; done with state_out={64'h8000000000000000,256'h0}.
- Partial block: state_in=0, pt_data=64'hAABBCC1122334455, pt_last=1, pt_bytes=3 -> ct_data=64'hAABBCC0000000000, ct_bytes=3; state_out x0=64'hAABBCC8000000000.
- Full block then empty last: x0=64'hFFFFFFFFFFFFFFFF, pt_data=64'h0123456789ABCDEF -> ct_data=64'hFEDCBA9876543210 one cycle after handshake; pt_ready low exactly 6 cycles; final state_out matches the golden ASCON model.
- Multi-block message: 4 full blocks plus a 5-byte last block from a known AD-stage state -> every ct block and state_out bit-exact to the reference software ASCON-128 encryptor.
- Reset during PERM (round 3): rst=1 for one cycle -> next cycle busy=0, pt_ready=0, state_out=0, FSM in IDLE; a new start then runs normally.
- Protocol checks:
  - start asserted while busy is ignored (state is not reloaded).
  - pt_valid held high during PERM produces no extra ct_valid.
